// File: rtl/hazard_ctrl.sv
// Hazard controller: destination scoreboard, registered EX bypass selects,
// and stall/bubble generation for load-use, flush and data-memory waits.
module hazard_ctrl #(
  parameter int RF_AW    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] p0_addr_ID,
  input  logic [RF_AW-1:0] p1_addr_ID,
  input  logic             re0_ID,
  input  logic             re1_ID,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             rf_we_ID,
  input  logic             dm_re_ID,
  input  logic             flush_ID_EX,
  input  logic             dm_busy,
  output logic             stall_IM_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             bubble_ID_EX,
  output logic             byp0_EX,
  output logic             byp1_EX,
  output logic             byp0_DM,
  output logic             byp1_DM,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dm_timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic             vld;
    logic             load;
    logic [RF_AW-1:0] dst;
  } sb_ex_t;

  typedef struct packed {
    logic             vld;
    logic [RF_AW-1:0] dst;
  } sb_dm_t;

  sb_ex_t          sb_ex;
  sb_dm_t          sb_dm;
  logic            m_ex0;
  logic            m_ex1;
  logic            m_dm0;
  logic            m_dm1;
  logic            lu;
  logic            kill;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_nxt;

  always_comb begin
    m_ex0 = re0_ID && sb_ex.vld && (sb_ex.dst == p0_addr_ID);
    m_ex1 = re1_ID && sb_ex.vld && (sb_ex.dst == p1_addr_ID);
    m_dm0 = re0_ID && sb_dm.vld && (sb_dm.dst == p0_addr_ID);
    m_dm1 = re1_ID && sb_dm.vld && (sb_dm.dst == p1_addr_ID);
    lu    = (m_ex0 || m_ex1) && sb_ex.load;
    kill  = flush_ID_EX || lu;
  end

  // Stalls are combinational and forced low while reset is asserted.
  always_comb begin
    stall_IM_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    bubble_ID_EX = 1'b0;
    if (!rst) begin
      if (dm_busy) begin
        stall_IM_ID = 1'b1;
        stall_ID_EX = 1'b1;
        stall_EX_DM = 1'b1;
      end else if (flush_ID_EX) begin
        bubble_ID_EX = 1'b1;
      end else if (lu) begin
        stall_IM_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (dm_busy) begin
      if (wait_cnt == WW'(MAX_WAIT)) wait_nxt = wait_cnt;
      else                           wait_nxt = wait_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex      <= '0;
      sb_dm      <= '0;
      byp0_EX    <= 1'b0;
      byp1_EX    <= 1'b0;
      byp0_DM    <= 1'b0;
      byp1_DM    <= 1'b0;
      stall_cnt  <= '0;
      wait_cnt   <= '0;
      dm_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == WW'(MAX_WAIT)) dm_timeout <= 1'b1;
      if (stall_IM_ID && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!dm_busy) begin
        sb_dm <= '{vld: sb_ex.vld, dst: sb_ex.dst};
        if (kill) begin
          sb_ex   <= '0;
          byp0_EX <= 1'b0;
          byp1_EX <= 1'b0;
          byp0_DM <= 1'b0;
          byp1_DM <= 1'b0;
        end else begin
          sb_ex <= '{vld:  rf_we_ID && (dst_addr_ID != '0),
                     load: dm_re_ID,
                     dst:  dst_addr_ID};
          byp0_EX <= m_ex0;
          byp1_EX <= m_ex1;
          byp0_DM <= m_dm0 && !m_ex0;
          byp1_DM <= m_dm1 && !m_ex1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic
// against an instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr_ID;
  logic [AW-1:0] p1_addr_ID;
  logic          re0_ID;
  logic          re1_ID;
  logic [AW-1:0] dst_addr_ID;
  logic          rf_we_ID;
  logic          dm_re_ID;
  logic          flush_ID_EX;
  logic          dm_busy;
  logic          stall_IM_ID;
  logic          stall_ID_EX;
  logic          stall_EX_DM;
  logic          bubble_ID_EX;
  logic          byp0_EX;
  logic          byp1_EX;
  logic          byp0_DM;
  logic          byp1_DM;
  logic [CW-1:0] stall_cnt;
  logic          dm_timeout;

  always #5 clk = ~clk;

  hazard_ctrl #(.RF_AW(AW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .re0_ID(re0_ID), .re1_ID(re1_ID),
    .dst_addr_ID(dst_addr_ID), .rf_we_ID(rf_we_ID),
    .dm_re_ID(dm_re_ID), .flush_ID_EX(flush_ID_EX),
    .dm_busy(dm_busy),
    .stall_IM_ID(stall_IM_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .bubble_ID_EX(bubble_ID_EX),
    .byp0_EX(byp0_EX), .byp1_EX(byp1_EX),
    .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
    .stall_cnt(stall_cnt), .dm_timeout(dm_timeout)
  );

  typedef struct {
    bit          we;
    bit          ld;
    logic [AW-1:0] dst;
  } ins_t;

  ins_t m_ex, m_dm;
  bit   e_b0x, e_b1x, e_b0d, e_b1d, e_to;
  int   e_cnt, e_wait;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit dep(ins_t x, bit re, logic [AW-1:0] a);
    return re && x.we && (x.dst != 0) && (x.dst == a);
  endfunction

  task automatic set_id(bit we, bit ld, int dst,
                        bit r0, int a0, bit r1, int a1);
    rf_we_ID    = we;
    dm_re_ID    = ld;
    dst_addr_ID = AW'(dst);
    re0_ID      = r0;
    p0_addr_ID  = AW'(a0);
    re1_ID      = r1;
    p1_addr_ID  = AW'(a1);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check all outputs at negedge, then advance the model.
  task automatic cyc();
    bit d0x, d1x, d0d, d1d, lu;
    bit s_if, s_id, s_ex, bub;
    @(negedge clk);
    d0x = dep(m_ex, re0_ID, p0_addr_ID);
    d1x = dep(m_ex, re1_ID, p1_addr_ID);
    d0d = dep(m_dm, re0_ID, p0_addr_ID);
    d1d = dep(m_dm, re1_ID, p1_addr_ID);
    lu  = (d0x || d1x) && m_ex.ld;
    s_if = 0; s_id = 0; s_ex = 0; bub = 0;
    if (!rst) begin
      if (dm_busy) begin
        s_if = 1; s_id = 1; s_ex = 1;
      end else if (flush_ID_EX || lu) begin
        bub  = 1;
        s_if = !flush_ID_EX;
      end
    end
    chk("stall_if", stall_IM_ID, s_if);
    chk("stall_id", stall_ID_EX, s_id);
    chk("stall_ex", stall_EX_DM, s_ex);
    chk("bubble", bubble_ID_EX, bub);
    chk("byp0_ex", byp0_EX, e_b0x);
    chk("byp1_ex", byp1_EX, e_b1x);
    chk("byp0_dm", byp0_DM, e_b0d);
    chk("byp1_dm", byp1_DM, e_b1d);
    chk("stall_cnt", stall_cnt, e_cnt);
    chk("timeout", dm_timeout, e_to);
    @(posedge clk);
    if (rst) begin
      m_ex = '{0, 0, 0};
      m_dm = '{0, 0, 0};
      {e_b0x, e_b1x, e_b0d, e_b1d, e_to} = '0;
      e_cnt = 0;
      e_wait = 0;
    end else begin
      if (s_if && e_cnt < (1 << CW) - 1) e_cnt++;
      if (dm_busy) begin
        e_wait++;
        if (e_wait >= MW) e_to = 1;
      end else begin
        e_wait = 0;
        m_dm = m_ex;
        if (flush_ID_EX || lu) begin
          m_ex = '{0, 0, 0};
          {e_b0x, e_b1x, e_b0d, e_b1d} = '0;
        end else begin
          m_ex  = '{rf_we_ID, dm_re_ID, dst_addr_ID};
          e_b0x = d0x;
          e_b1x = d1x;
          e_b0d = d0d && !d0x;
          e_b1d = d1d && !d1x;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; flush_ID_EX = 0; dm_busy = 0;
    nop();
    cyc();
    rst = 0;
  endtask

  initial begin
    m_ex = '{0, 0, 0};
    m_dm = '{0, 0, 0};
    {e_b0x, e_b1x, e_b0d, e_b1d, e_to} = '0;
    e_cnt = 0; e_wait = 0;
    rst = 1; flush_ID_EX = 0; dm_busy = 0;
    nop();
    @(posedge clk); #1;
    do_reset();

    // back-to-back dependency: EX bypass on both sources
    set_id(1, 0, 3, 1, 1, 1, 2); cyc();
    set_id(1, 0, 4, 1, 3, 1, 3); cyc();
    chk("t1_b0x", byp0_EX, 1);
    chk("t1_b1x", byp1_EX, 1);
    chk("t1_cnt", stall_cnt, 0);

    // one instruction gap: DM bypass on source 0 only
    do_reset();
    set_id(1, 0, 3, 1, 1, 1, 2); cyc();
    nop(); cyc();
    set_id(1, 0, 5, 1, 3, 1, 1); cyc();
    chk("t2_b0d", byp0_DM, 1);
    chk("t2_b0x", byp0_EX, 0);
    chk("t2_b1x", byp1_EX, 0);
    chk("t2_b1d", byp1_DM, 0);

    // load-use: one bubble then DM bypass
    do_reset();
    set_id(1, 1, 2, 1, 1, 0, 0); cyc();
    set_id(1, 0, 6, 1, 2, 1, 7);
    #2;
    chk("t3_stall", stall_IM_ID, 1);
    chk("t3_bub", bubble_ID_EX, 1);
    cyc();
    chk("t3_nostall", stall_IM_ID, 0);
    cyc();
    chk("t3_b0d", byp0_DM, 1);
    chk("t3_b0x", byp0_EX, 0);
    chk("t3_cnt", stall_cnt, 1);

    // r0 is never bypassed; unread port ignored
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 0); cyc();
    set_id(1, 0, 8, 1, 0, 1, 0); cyc();
    chk("t4_r0a", {byp0_EX, byp1_EX, byp0_DM, byp1_DM}, 0);
    set_id(1, 0, 5, 0, 0, 0, 0); cyc();
    set_id(1, 0, 9, 1, 5, 0, 5); cyc();
    chk("t4_b0x", byp0_EX, 1);
    chk("t4_b1x", byp1_EX, 0);

    // dm_busy during load-use
    do_reset();
    set_id(1, 1, 2, 0, 0, 0, 0); cyc();
    set_id(1, 0, 6, 1, 2, 1, 7);
    dm_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t5_hold", {stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX}, 4'b1110);
      cyc();
    end
    dm_busy = 0;
    #2;
    chk("t5_bub", bubble_ID_EX, 1);
    cyc();
    cyc();
    chk("t5_cnt", stall_cnt, 4);
    chk("t5_b0d", byp0_DM, 1);

    // flush squashes the ID instruction
    do_reset();
    set_id(1, 0, 3, 0, 0, 0, 0);
    flush_ID_EX = 1; cyc();
    flush_ID_EX = 0;
    set_id(1, 0, 4, 1, 3, 0, 0); cyc();
    chk("t7_flush", {byp0_EX, byp0_DM}, 0);

    // wait timeout, then reset clears it
    do_reset();
    nop();
    dm_busy = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 3) chk("t6_to3", dm_timeout, 0);
      if (i == 4) chk("t6_to4", dm_timeout, 1);
    end
    dm_busy = 0; cyc(); cyc();
    chk("t6_sticky", dm_timeout, 1);
    do_reset();
    chk("t6_rto", dm_timeout, 0);
    chk("t6_rcnt", stall_cnt, 0);

    // stall counter saturation
    dm_busy = 1;
    for (int i = 0; i < 20; i++) cyc();
    chk("t8_sat", stall_cnt, (1 << CW) - 1);
    dm_busy = 1;
    rst = 1;
    #2;
    chk("t9_rststall", {stall_IM_ID, bubble_ID_EX}, 0);
    cyc();
    rst = 0; dm_busy = 0;

    // random traffic on a small register set
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 1), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3));
      dm_busy     = ($urandom_range(0, 7) == 0);
      flush_ID_EX = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
